// File: rtl/reg_move_sequencer.sv
// rtl/reg_move_sequencer.sv - micro-op sequencer for MOV/MVI/XCHG on the 8-register bank
module reg_move_sequencer #(
    parameter int DATA_W = 8
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              start,
    input  logic [7:0]        opcode,
    input  logic [7:0]        imm,
    input  logic [DATA_W-1:0] bank_dout,
    output logic [2:0]        rs,
    output logic              rd,
    output logic              wr,
    output logic              en,
    output logic [DATA_W-1:0] bus_out,
    output logic              busy,
    output logic              done,
    output logic              illegal
);

    typedef enum logic [1:0] {IDLE, EXEC, DONE} state_t;
    typedef enum logic [1:0] {K_MOV, K_MVI, K_XCHG, K_ILL} kind_t;

    // act: cycle touches the bank; wrt: write (else read); ts: temporary t1 (else t0)
    typedef struct packed {
        logic       act;
        logic       wrt;
        logic [2:0] r;
        logic       ts;
    } uop_t;

    localparam logic [2:0] R_D = 3'd2;
    localparam logic [2:0] R_E = 3'd3;
    localparam logic [2:0] R_H = 3'd4;
    localparam logic [2:0] R_L = 3'd5;

    state_t            state, state_n;
    kind_t             kind, kind_n, dec_kind;
    logic [2:0]        step, step_n, ddd, ddd_n, sss, sss_n;
    logic [DATA_W-1:0] t0, t1, t0_n, t1_n;
    logic              ready, accept, ill_n;
    uop_t              cur, nxt;

    function automatic kind_t decode(input logic [7:0] op);
        if (op == 8'h76)                             return K_ILL;
        else if (op[7:6] == 2'b01)                   return K_MOV;
        else if (op[7:6] == 2'b00 && op[2:0] == 3'b110) return K_MVI;
        else if (op == 8'hEB)                        return K_XCHG;
        else                                         return K_ILL;
    endfunction

    function automatic logic [2:0] last_step(input kind_t k);
        case (k)
            K_MOV:   return 3'd1;
            K_XCHG:  return 3'd7;
            default: return 3'd0;
        endcase
    endfunction

    function automatic uop_t uop_at(input kind_t k, input logic [2:0] s,
                                    input logic [2:0] d, input logic [2:0] src);
        uop_t u;
        u = '0;
        case (k)
            K_MOV:  u = (s == 3'd0) ? {1'b1, 1'b0, src, 1'b0} : {1'b1, 1'b1, d, 1'b0};
            K_MVI:  u = {1'b1, 1'b1, d, 1'b0};
            K_XCHG: begin
                case (s)
                    3'd0:    u = {1'b1, 1'b0, R_H, 1'b0};
                    3'd1:    u = {1'b1, 1'b0, R_D, 1'b1};
                    3'd2:    u = {1'b1, 1'b1, R_H, 1'b1};
                    3'd3:    u = {1'b1, 1'b1, R_D, 1'b0};
                    3'd4:    u = {1'b1, 1'b0, R_L, 1'b0};
                    3'd5:    u = {1'b1, 1'b0, R_E, 1'b1};
                    3'd6:    u = {1'b1, 1'b1, R_L, 1'b1};
                    default: u = {1'b1, 1'b1, R_E, 1'b0};
                endcase
            end
            default: u = '0;
        endcase
        return u;
    endfunction

    always_comb begin
        ready    = (state == IDLE) || (state == DONE);
        accept   = ready && start;
        dec_kind = decode(opcode);
        cur      = uop_at(kind, step, ddd, sss);

        // Next-temporary values are forwarded so a write right after a read sees fresh data
        t0_n = t0;
        t1_n = t1;
        if (accept && dec_kind == K_MVI)
            t0_n = imm;
        else if (state == EXEC && cur.act && !cur.wrt) begin
            if (cur.ts) t1_n = bank_dout;
            else        t0_n = bank_dout;
        end

        nxt     = '0;
        state_n = state;
        step_n  = step;
        kind_n  = kind;
        ddd_n   = ddd;
        sss_n   = sss;
        ill_n   = 1'b0;
        if (accept) begin
            kind_n = dec_kind;
            ddd_n  = opcode[5:3];
            sss_n  = opcode[2:0];
            step_n = 3'd0;
            if (dec_kind == K_ILL) begin
                state_n = DONE;
                ill_n   = 1'b1;
            end else begin
                state_n = EXEC;
                nxt     = uop_at(dec_kind, 3'd0, opcode[5:3], opcode[2:0]);
            end
        end else if (state == EXEC) begin
            if (step == last_step(kind)) begin
                state_n = DONE;
            end else begin
                step_n = step + 3'd1;
                nxt    = uop_at(kind, step + 3'd1, ddd, sss);
            end
        end else if (state == DONE) begin
            state_n = IDLE;
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state   <= IDLE;
            kind    <= K_ILL;
            step    <= 3'd0;
            ddd     <= 3'd0;
            sss     <= 3'd0;
            t0      <= '0;
            t1      <= '0;
            rs      <= 3'd0;
            rd      <= 1'b0;
            wr      <= 1'b0;
            en      <= 1'b0;
            bus_out <= '0;
            busy    <= 1'b0;
            done    <= 1'b0;
            illegal <= 1'b0;
        end else begin
            state   <= state_n;
            kind    <= kind_n;
            step    <= step_n;
            ddd     <= ddd_n;
            sss     <= sss_n;
            t0      <= t0_n;
            t1      <= t1_n;
            rs      <= nxt.r;
            rd      <= nxt.act & ~nxt.wrt;
            wr      <= nxt.act & nxt.wrt;
            en      <= nxt.act;
            bus_out <= (nxt.act && nxt.wrt) ? (nxt.ts ? t1_n : t0_n) : '0;
            busy    <= (state_n == EXEC);
            done    <= (state_n == DONE);
            illegal <= ill_n;
        end
    end

endmodule
